busio: RTL and testbench
========================

Name: busio

Overview:
Bus responder for the data-memory port driven by the memory pipeline stage.
- Accepts single-beat load/store requests (mem_addr, mem_store_data, mem_load, mem_store) plus access size and signedness.
- Converts each request into a word-aligned valid/ready transaction on the external data bus, with byte strobes.
- Holds the pipeline via bus_stall until the response returns, then presents lane-aligned, sign/zero-extended load data on mem_load_data.

Parameters:
TIMEOUT_CYCLES, 255, cycles in WAIT_RESP before abort; used only with BUSIO_TIMEOUT_EN.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
mem_addr  in  32  byte address from memory stage
mem_store_data  in  32  raw rs2 store data
mem_load  in  1  load request, level, held while bus_stall=1
mem_store  in  1  store request, level, held while bus_stall=1
load_store_size  in  2  00 byte, 01 half, 10 word
load_signed  in  1  sign-extend load result
mem_load_data  out  32  extended load result to memory stage
bus_stall  out  1  to hazard unit; stall pipeline
bus_error  out  1  timeout indication, valid in DONE cycle
ext_valid  out  1  request valid
ext_ready  in  1  request accepted
ext_addr  out  32  {mem_addr[31:2],2'b00}
ext_write  out  1  1=store
ext_wdata  out  32  lane-replicated store data
ext_wstrb  out  4  byte enables
ext_rvalid  in  1  response valid (read data or write ack)
ext_rdata  in  32  read data word

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - ext_valid=0, ext_write=0, ext_addr=0, ext_wdata=0, ext_wstrb=0.
  - Response register=0, so mem_load_data=0; bus_error=0.
  - Reset mid-transaction abandons it; ext_valid drops immediately and any later ext_rvalid is ignored.
- FSM states: IDLE, REQ, WAIT_RESP, DONE.
- IDLE:
  - If mem_load or mem_store is high, latch addr, size, signed, write=mem_store (store has priority if both are high), wdata and wstrb; go to REQ.
  - bus_stall = mem_load | mem_store (combinational).
- REQ:
  - ext_valid=1, with all ext_* fields stable until ext_ready.
  - On ext_ready: go to DONE if ext_rvalid is also high this cycle (capture rdata), else go to WAIT_RESP.
  - bus_stall=1.
- WAIT_RESP:
  - ext_valid=0; on ext_rvalid, capture ext_rdata and go to DONE.
  - bus_stall=1.
- DONE:
  - bus_stall=0 for exactly one cycle; the pipeline samples mem_load_data at the edge ending DONE.
  - Next state is always IDLE. Requests are never re-issued from DONE.
- Minimum latency: request seen in cycle 0, REQ in 1, DONE in 2, so a 3-cycle occupancy with a zero-wait responder.
- Store encoding:
  - Byte: wdata={4{d[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - Half: wdata={2{d[15:0]}}, wstrb=4'b0011<<{addr[1],1'b0}.
  - Word: wdata=d, wstrb=4'b1111.
  - size 11 is encoded as word.
- Load extraction:
  - shifted = rdata >> (addr[1:0]*8).
  - Byte and half results are extended from bit 7 / bit 15 when load_signed=1, else zero-extended. Word results pass through.
  - mem_load_data is derived from the registered word and latched attributes; it is stable from DONE until the next capture.
- Store responses: rdata is ignored; mem_load_data is unspecified for stores (the writeback stage does not select it).
- Misaligned addresses never arrive (filtered upstream). Behaviour for them is lane truncation as above, with no error.
- ext_rvalid outside REQ/WAIT_RESP is ignored.

Optional Feature:
BUSIO_TIMEOUT_EN
- Defined:
  - An 8-bit or wider counter (sized to TIMEOUT_CYCLES) clears on entry to REQ and counts in REQ/WAIT_RESP.
  - When it reaches TIMEOUT_CYCLES, drop ext_valid, go to DONE with bus_error=1 and mem_load_data=0.
  - bus_error is 0 in all other cycles.
- Not defined: no counter; the FSM waits forever; bus_error is tied to 0.

Decomposition:
- Shared package: FSM state encoding; load_store_size encodings (SIZE_BYTE/HALF/WORD); BUSIO_TIMEOUT default.
- One sub-module, busio_lane: purely combinational store-replicate/strobe and load-extract logic. Instantiated once and shared between the request and response sides.

Test Plan:
1. Zero-wait word load, addr=0x100, ext_rdata=0xDEADBEEF, ready and rvalid immediate -> ext_addr=0x100, wstrb=0, bus_stall high 2 cycles, DONE mem_load_data=0xDEADBEEF.
2. Signed byte load addr=0x203, rdata=0x80FFFFFF -> mem_load_data=0xFFFFFF80; unsigned -> 0x00000080; half signed addr=0x202 -> 0xFFFF80FF.
3. Half store addr=0x302, data=0x1234ABCD, ext_ready delayed 3 cycles -> ext_valid held 4 cycles with wdata=0xABCDABCD, wstrb=4'b1100 stable; bus_stall until ack+DONE.
4. Back-to-back store then load -> exactly one DONE per request, no duplicate ext_valid, one idle cycle between transactions.
5. rst_n low while in WAIT_RESP -> ext_valid=0, bus_stall=0, mem_load_data=0 immediately; a late ext_rvalid after release causes no DONE.
6. BUSIO_TIMEOUT_EN, TIMEOUT_CYCLES=4, no rvalid -> DONE after 4 wait cycles, bus_error=1 for one cycle, mem_load_data=0.

Source files
------------

// File: rtl/busio_pkg.sv
// ============================================================================
// Module      : busio_pkg
// Description : Shared types and constants for the data-memory bus responder:
//               FSM state encoding, access-size encodings, timeout default.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package busio_pkg;

  // Transaction FSM states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_RESP = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  // load_store_size encodings; 2'b11 is treated as a word access
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Default response timeout, in cycles spent in REQ/WAIT_RESP
  localparam int BUSIO_TIMEOUT = 255;

endpackage : busio_pkg

`default_nettype wire

// File: rtl/busio_lane.sv
// ============================================================================
// Module      : busio_lane
// Description : Purely combinational byte-lane logic. Store side replicates
//               store data across lanes and builds byte strobes; load side
//               shifts the returned word down and sign/zero-extends it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module busio_lane
  import busio_pkg::*;
(
  // store side (fed from the live request)
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wstrb,
  // load side (fed from the latched request and captured word)
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_addr_lo,
  input  logic        ld_signed,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] w_shifted;

  // Bring the addressed lane down to bit 0; misaligned accesses just truncate
  assign w_shifted = ld_rdata >> {ld_addr_lo, 3'b000};

  // Store lane replication and strobe generation
  always_comb begin
    st_wdata = st_data;
    st_wstrb = 4'b1111;
    case (st_size)
      SIZE_BYTE: begin
        st_wdata = {4{st_data[7:0]}};
        st_wstrb = 4'b0001 << st_addr_lo;
      end
      SIZE_HALF: begin
        st_wdata = {2{st_data[15:0]}};
        st_wstrb = 4'b0011 << {st_addr_lo[1], 1'b0};
      end
      default: begin
        st_wdata = st_data;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Load extraction with sign or zero extension
  always_comb begin
    ld_data = w_shifted;
    case (ld_size)
      SIZE_BYTE: ld_data = {{24{ld_signed & w_shifted[7]}},  w_shifted[7:0]};
      SIZE_HALF: ld_data = {{16{ld_signed & w_shifted[15]}}, w_shifted[15:0]};
      default:   ld_data = w_shifted;
    endcase
  end

endmodule : busio_lane

`default_nettype wire

// File: rtl/busio.sv
// ============================================================================
// Module      : busio
// Description : Data-memory bus responder. Turns single-beat load/store
//               requests from the memory stage into word-aligned valid/ready
//               transactions with byte strobes, stalls the pipeline until the
//               response returns, and presents extended load data.
//               Optional feature macro: BUSIO_TIMEOUT_EN (response timeout
//               with bus_error indication). Default build waits forever.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module busio
  import busio_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = BUSIO_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  // memory stage side
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_store_data,
  input  logic        mem_load,
  input  logic        mem_store,
  input  logic [1:0]  load_store_size,
  input  logic        load_signed,
  output logic [31:0] mem_load_data,
  output logic        bus_stall,
  output logic        bus_error,
  // external data bus
  output logic        ext_valid,
  input  logic        ext_ready,
  output logic [31:0] ext_addr,
  output logic        ext_write,
  output logic [31:0] ext_wdata,
  output logic [3:0]  ext_wstrb,
  input  logic        ext_rvalid,
  input  logic [31:0] ext_rdata
);

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_signed;
  logic        r_write;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_rdata;

  logic [31:0] w_lane_wdata;
  logic [3:0]  w_lane_wstrb;
  logic [31:0] w_lane_load;

  logic        w_req;
  logic        w_latch;
  logic        w_resp;
  logic        w_timeout;

  assign w_req = mem_load | mem_store;

  // A response completes the transaction: in REQ it must coincide with the
  // handshake, in WAIT_RESP rvalid alone suffices; elsewhere it is ignored
  assign w_resp = ((r_state == ST_REQ) && ext_ready && ext_rvalid) ||
                  ((r_state == ST_WAIT_RESP) && ext_rvalid);

  busio_lane u_lane (
    .st_size    (load_store_size),
    .st_addr_lo (mem_addr[1:0]),
    .st_data    (mem_store_data),
    .st_wdata   (w_lane_wdata),
    .st_wstrb   (w_lane_wstrb),
    .ld_size    (r_size),
    .ld_addr_lo (r_addr[1:0]),
    .ld_signed  (r_signed),
    .ld_rdata   (r_rdata),
    .ld_data    (w_lane_load)
  );

`ifdef BUSIO_TIMEOUT_EN
  localparam int c_cnt_w = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                           $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [c_cnt_w-1:0] r_count;
  logic               r_error;

  // Abort on the last counted cycle unless the response arrives in it
  assign w_timeout = ((r_state == ST_REQ) || (r_state == ST_WAIT_RESP)) &&
                     (r_count == c_cnt_w'(TIMEOUT_CYCLES - 1)) && !w_resp;

  // Timeout counter and sticky error flag for the current transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_error <= 1'b0;
    end else begin
      if (w_latch) begin
        r_count <= '0;
        r_error <= 1'b0;
      end else if ((r_state == ST_REQ) || (r_state == ST_WAIT_RESP)) begin
        r_count <= r_count + 1'b1;
      end
      if (w_timeout) begin
        r_error <= 1'b1;
      end
    end
  end

  assign bus_error = (r_state == ST_DONE) && r_error;
`else
  assign w_timeout = 1'b0;
  assign bus_error = 1'b0;

  // TIMEOUT_CYCLES only sizes the timeout counter, which is absent here
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state, request valid and pipeline stall
  always_comb begin
    w_next    = r_state;
    w_latch   = 1'b0;
    ext_valid = 1'b0;
    bus_stall = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus_stall = w_req;
        if (w_req) begin
          w_latch = 1'b1;
          w_next  = ST_REQ;
        end
      end
      ST_REQ: begin
        bus_stall = 1'b1;
        ext_valid = 1'b1;
        if (w_resp) begin
          w_next = ST_DONE;
        end else if (w_timeout) begin
          w_next = ST_DONE;
        end else if (ext_ready) begin
          w_next = ST_WAIT_RESP;
        end
      end
      ST_WAIT_RESP: begin
        bus_stall = 1'b1;
        if (w_resp || w_timeout) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Request latch and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_size   <= SIZE_BYTE;
      r_signed <= 1'b0;
      r_write  <= 1'b0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_latch) begin
        r_addr   <= mem_addr;
        r_size   <= load_store_size;
        r_signed <= load_signed;
        r_write  <= mem_store;
        r_wdata  <= mem_store ? w_lane_wdata : 32'h0;
        r_wstrb  <= mem_store ? w_lane_wstrb : 4'h0;
      end
      // Store acks carry no data; keep the last load word instead
      if (w_resp && !r_write) begin
        r_rdata <= ext_rdata;
      end else if (w_timeout) begin
        r_rdata <= '0;
      end
    end
  end

  assign ext_addr      = {r_addr[31:2], 2'b00};
  assign ext_write     = r_write;
  assign ext_wdata     = r_wdata;
  assign ext_wstrb     = r_wstrb;
  assign mem_load_data = w_lane_load;

endmodule : busio

`default_nettype wire

// File: tb/tb_busio.sv
// ============================================================================
// Module      : tb_busio
// Description : Self-checking bench for busio: directed vector table,
//               reset-abort sequence, randomized transactions against a
//               lane-level reference model, and (with BUSIO_TIMEOUT_EN) a
//               timeout sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_busio;

  localparam int TB_TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic [31:0] mem_store_data;
  logic        mem_load;
  logic        mem_store;
  logic [1:0]  load_store_size;
  logic        load_signed;
  logic [31:0] mem_load_data;
  logic        bus_stall;
  logic        bus_error;
  logic        ext_valid;
  logic        ext_ready;
  logic [31:0] ext_addr;
  logic        ext_write;
  logic [31:0] ext_wdata;
  logic [3:0]  ext_wstrb;
  logic        ext_rvalid;
  logic [31:0] ext_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  busio #(.TIMEOUT_CYCLES(TB_TMO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_addr        (mem_addr),
    .mem_store_data  (mem_store_data),
    .mem_load        (mem_load),
    .mem_store       (mem_store),
    .load_store_size (load_store_size),
    .load_signed     (load_signed),
    .mem_load_data   (mem_load_data),
    .bus_stall       (bus_stall),
    .bus_error       (bus_error),
    .ext_valid       (ext_valid),
    .ext_ready       (ext_ready),
    .ext_addr        (ext_addr),
    .ext_write       (ext_write),
    .ext_wdata       (ext_wdata),
    .ext_wstrb       (ext_wstrb),
    .ext_rvalid      (ext_rvalid),
    .ext_rdata       (ext_rdata)
  );

  typedef struct {
    logic        st;
    logic [31:0] a;
    logic [1:0]  sz;
    logic        sgn;
    logic [31:0] d;
    logic [31:0] rd;
    int          rdy;
    int          rv;
    logic [31:0] ew;
    logic [3:0]  es;
    logic [31:0] el;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  // Reference load: pick the addressed bytes, then extend arithmetically
  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz,
                                         input logic sgn, input logic [31:0] rd);
    int          nb = nbytes(sz);
    longint      v;
    logic [63:0] r;
    v = longint'(rd >> (8 * int'(a[1:0])));
    if (nb < 4) begin
      v = v % (longint'(1) << (8 * nb));
      if (sgn && v >= (longint'(1) << (8 * nb - 1)))
        v = v - (longint'(1) << (8 * nb));
    end
    r = v;
    return r[31:0];
  endfunction

  // Reference store: every lane carries byte (lane mod size); strobe covers
  // the naturally aligned group containing the address
  task automatic m_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                         output logic [31:0] w, output logic [3:0] s);
    int nb = nbytes(sz);
    int base;
    base = (nb == 4) ? 0 : (nb == 2) ? (int'(a[1:0]) / 2) * 2 : int'(a[1:0]);
    w = '0;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      w = w | (((d >> (8 * (i % nb))) & 32'hFF) << (8 * i));
      if (i >= base && i < base + nb) s[i] = 1'b1;
    end
  endtask

  task automatic run_txn(input logic st, input logic [31:0] a, input logic [1:0] sz,
                         input logic sgn, input logic [31:0] d, input logic [31:0] rd,
                         input int rdy, input int rv, input logic [31:0] ew,
                         input logic [3:0] es, input logic [31:0] el);
    mem_addr        = a;
    mem_store_data  = d;
    mem_store       = st;
    mem_load        = !st;
    load_store_size = sz;
    load_signed     = sgn;
    ext_ready       = 1'b0;
    ext_rvalid      = 1'b0;
    @(negedge clk);
    chk("idle_stall", {31'b0, bus_stall}, 32'd1);
    chk("idle_valid", {31'b0, ext_valid}, 32'd0);
    @(posedge clk); #1;
    for (int k = 0; k <= rdy; k++) begin
      ext_ready  = (k == rdy);
      ext_rvalid = (k == rdy) && (rv == 0);
      ext_rdata  = (k == rdy && rv == 0) ? rd : $urandom;
      @(negedge clk);
      chk("req_valid", {31'b0, ext_valid}, 32'd1);
      chk("req_stall", {31'b0, bus_stall}, 32'd1);
      chk("req_addr", ext_addr, {a[31:2], 2'b00});
      chk("req_write", {31'b0, ext_write}, {31'b0, st});
      chk("req_wstrb", {28'b0, ext_wstrb}, {28'b0, es});
      if (st) chk("req_wdata", ext_wdata, ew);
      @(posedge clk); #1;
    end
    for (int j = 1; j <= rv; j++) begin
      ext_ready  = 1'b0;
      ext_rvalid = (j == rv);
      ext_rdata  = (j == rv) ? rd : $urandom;
      @(negedge clk);
      chk("wait_valid", {31'b0, ext_valid}, 32'd0);
      chk("wait_stall", {31'b0, bus_stall}, 32'd1);
      @(posedge clk); #1;
    end
    ext_ready  = 1'b0;
    ext_rvalid = 1'b0;
    ext_rdata  = $urandom;
    @(negedge clk);
    chk("done_stall", {31'b0, bus_stall}, 32'd0);
    chk("done_valid", {31'b0, ext_valid}, 32'd0);
    chk("done_error", {31'b0, bus_error}, 32'd0);
    if (!st) chk("done_data", mem_load_data, el);
    @(posedge clk); #1;
    mem_load  = 1'b0;
    mem_store = 1'b0;
  endtask

  initial begin
    logic [31:0] ew;
    logic [3:0]  es;
    logic [31:0] a;
    logic [1:0]  sz;
    logic        st;
    logic        sgn;
    logic [31:0] d;
    logic [31:0] rd;

    vt[0]  = '{1'b0, 32'h100, 2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 0, 0, 32'h0,        4'b0000, 32'hDEADBEEF};
    vt[1]  = '{1'b0, 32'h203, 2'd0, 1'b1, 32'h0,        32'h80FFFFFF, 0, 0, 32'h0,        4'b0000, 32'hFFFFFF80};
    vt[2]  = '{1'b0, 32'h203, 2'd0, 1'b0, 32'h0,        32'h80FFFFFF, 0, 0, 32'h0,        4'b0000, 32'h00000080};
    vt[3]  = '{1'b0, 32'h202, 2'd1, 1'b1, 32'h0,        32'h80FFFFFF, 0, 0, 32'h0,        4'b0000, 32'hFFFF80FF};
    vt[4]  = '{1'b1, 32'h302, 2'd1, 1'b0, 32'h1234ABCD, 32'h0,        3, 0, 32'hABCDABCD, 4'b1100, 32'h0};
    vt[5]  = '{1'b1, 32'h101, 2'd0, 1'b0, 32'h000000AB, 32'h0,        0, 1, 32'hABABABAB, 4'b0010, 32'h0};
    vt[6]  = '{1'b0, 32'h200, 2'd1, 1'b0, 32'h0,        32'h1234F00D, 2, 3, 32'h0,        4'b0000, 32'h0000F00D};
    vt[7]  = '{1'b1, 32'h400, 2'd2, 1'b0, 32'hCAFEF00D, 32'h0,        1, 2, 32'hCAFEF00D, 4'b1111, 32'h0};
    vt[8]  = '{1'b0, 32'h500, 2'd3, 1'b1, 32'h0,        32'h13579BDF, 0, 0, 32'h0,        4'b0000, 32'h13579BDF};
    vt[9]  = '{1'b0, 32'h201, 2'd0, 1'b1, 32'h0,        32'h00007F00, 0, 2, 32'h0,        4'b0000, 32'h0000007F};
    vt[10] = '{1'b0, 32'h200, 2'd1, 1'b1, 32'h0,        32'h00008001, 1, 0, 32'h0,        4'b0000, 32'hFFFF8001};

    rst_n = 1'b0;
    mem_addr = '0; mem_store_data = '0; mem_load = 1'b0; mem_store = 1'b0;
    load_store_size = 2'd0; load_signed = 1'b0;
    ext_ready = 1'b0; ext_rvalid = 1'b0; ext_rdata = '0;

    // Reset values
    #12;
    chk("rst_valid", {31'b0, ext_valid}, 32'd0);
    chk("rst_write", {31'b0, ext_write}, 32'd0);
    chk("rst_addr", ext_addr, 32'd0);
    chk("rst_wdata", ext_wdata, 32'd0);
    chk("rst_wstrb", {28'b0, ext_wstrb}, 32'd0);
    chk("rst_data", mem_load_data, 32'd0);
    chk("rst_error", {31'b0, bus_error}, 32'd0);
    chk("rst_stall", {31'b0, bus_stall}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table, issued back to back
    for (int i = 0; i < 11; i++) begin
      run_txn(vt[i].st, vt[i].a, vt[i].sz, vt[i].sgn, vt[i].d, vt[i].rd,
              vt[i].rdy, vt[i].rv, vt[i].ew, vt[i].es, vt[i].el);
    end
    @(negedge clk);
    chk("post_idle_valid", {31'b0, ext_valid}, 32'd0);
    chk("post_idle_stall", {31'b0, bus_stall}, 32'd0);
    @(posedge clk); #1;

    // Reset while waiting for the response
    mem_addr = 32'h600; load_store_size = 2'd2; load_signed = 1'b0;
    mem_load = 1'b1; mem_store = 1'b0;
    @(posedge clk); #1;
    ext_ready = 1'b1; ext_rvalid = 1'b0;
    @(posedge clk); #1;
    ext_ready = 1'b0;
    @(negedge clk);
    chk("abort_wait_stall", {31'b0, bus_stall}, 32'd1);
    mem_load = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", {31'b0, ext_valid}, 32'd0);
    chk("abort_stall", {31'b0, bus_stall}, 32'd0);
    chk("abort_data", mem_load_data, 32'd0);
    chk("abort_addr", ext_addr, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ext_rvalid = 1'b1; ext_rdata = 32'h55AA55AA;
    @(negedge clk);
    chk("late_rv_stall", {31'b0, bus_stall}, 32'd0);
    chk("late_rv_valid", {31'b0, ext_valid}, 32'd0);
    @(posedge clk); #1;
    ext_rvalid = 1'b0;
    @(negedge clk);
    chk("late_rv_data", mem_load_data, 32'd0);
    chk("late_rv_error", {31'b0, bus_error}, 32'd0);
    @(posedge clk); #1;

    // Randomized transactions against the reference model
    for (int n = 0; n < 40; n++) begin
      st  = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      sgn = 1'($urandom_range(0, 1));
      d   = $urandom;
      rd  = $urandom;
      a   = $urandom;
      if (nbytes(sz) == 2) a[0] = 1'b0;
      if (nbytes(sz) == 4) a[1:0] = 2'b00;
      if (st) begin
        m_store(a, sz, d, ew, es);
      end else begin
        ew = '0;
        es = '0;
      end
      run_txn(st, a, sz, sgn, d, rd, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              ew, es, m_load(a, sz, sgn, rd));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        chk("gap_valid", {31'b0, ext_valid}, 32'd0);
        chk("gap_stall", {31'b0, bus_stall}, 32'd0);
        @(posedge clk); #1;
      end
    end

`ifdef BUSIO_TIMEOUT_EN
    // No responder at all: abort after TB_TMO cycles with bus_error
    mem_addr = 32'h700; load_store_size = 2'd2; load_signed = 1'b0;
    mem_load = 1'b1; mem_store = 1'b0;
    ext_ready = 1'b0; ext_rvalid = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < TB_TMO; k++) begin
      @(negedge clk);
      chk("tmo_valid", {31'b0, ext_valid}, 32'd1);
      chk("tmo_stall", {31'b0, bus_stall}, 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("tmo_done_stall", {31'b0, bus_stall}, 32'd0);
    chk("tmo_done_error", {31'b0, bus_error}, 32'd1);
    chk("tmo_done_data", mem_load_data, 32'd0);
    chk("tmo_done_valid", {31'b0, ext_valid}, 32'd0);
    @(posedge clk); #1;
    mem_load = 1'b0;
    @(negedge clk);
    chk("tmo_after_error", {31'b0, bus_error}, 32'd0);
    @(posedge clk); #1;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_busio

`default_nettype wire
